ula_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the Neander ULA datapath (adder plus 4:1 operation mux: SUM/OR/AND/NOT).
- Accepts one instruction at a time (opcode + operand) over a valid/ready handshake.
- Owns the accumulator and the operand register, drives the ULA select, captures the result, and updates the N/Z flags.
- Sits between the instruction-decode stage and the ULA instance; the ULA itself stays combinational and external.

---
 rtl/ula_seq_ctrl_pkg.sv | 39 +++
 rtl/ula_seq_ctrl_if.sv | 14 +
 rtl/ula_seq_ctrl_flags.sv | 11 +
 rtl/ula_seq_ctrl.sv | 99 +++++++++
 tb/tb_ula_seq_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ula_seq_ctrl_pkg.sv
// Shared definitions for the Neander ULA sequencer: opcodes, ULA select codes,
// FSM state encoding and the default datapath width.
package ula_pkg;

  localparam int W_DEFAULT = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_LDA = 3'd4;
  localparam logic [2:0] OP_NOP = 3'd5;

  localparam logic [1:0] SEL_SUM = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RETIRE = 2'd2
  } state_t;

  // Non-ULA opcodes (LDA, NOP, illegal) park the mux on SUM.
  function automatic logic [1:0] sel_for_op(input logic [2:0] op);
    case (op)
      OP_OR:   sel_for_op = SEL_OR;
      OP_AND:  sel_for_op = SEL_AND;
      OP_NOT:  sel_for_op = SEL_NOT;
      default: sel_for_op = SEL_SUM;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    is_illegal = op[2] & op[1];
  endfunction

endpackage

// File: rtl/ula_seq_ctrl_if.sv
// Instruction handshake between the decode stage (master) and the sequencer (slave).
interface ula_seq_ctrl_if
  import ula_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_op, output in_data, input in_ready);
  modport slave  (input in_valid, input in_op, input in_data, output in_ready);
endinterface

// File: rtl/ula_seq_ctrl_flags.sv
// Combinational Neander N/Z flag derivation from a W-bit value.
module ula_flags #(
  parameter int W = 3
) (
  input  logic [W-1:0] value,
  output logic         n,
  output logic         z
);
  assign n = value[W-1];
  assign z = (value == '0);
endmodule

// File: rtl/ula_seq_ctrl.sv
// Three-state sequencer (IDLE/EXEC/RETIRE) that owns acc, the operand register
// and the flags around an external combinational ULA.
module ula_seq_ctrl
  import ula_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  ula_seq_ctrl_if.slave  ins,
  output logic [1:0]     alu_sel,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_s,
  output logic [W-1:0]   acc,
  output logic           flag_n,
  output logic           flag_z,
  output logic           done,
  output logic           err,
  output logic           busy
);

  state_t       state_q, state_d;
  logic [2:0]   opreg_q;
  logic [W-1:0] breg_q;
  logic [W-1:0] acc_q, acc_d;
  logic [1:0]   sel_q, sel_d;
  logic         flag_n_q, flag_z_q;
  logic         n_d, z_d;
  logic         accept;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ins.in_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
          sel_d   = sel_for_op(ins.in_op);
        end
      end
      ST_EXEC: begin
        state_d = ST_RETIRE;
        sel_d   = SEL_SUM;
        case (opreg_q)
          OP_ADD, OP_OR, OP_AND, OP_NOT: acc_d = alu_s;
          OP_LDA:                        acc_d = breg_q;
          default:                       acc_d = acc_q;
        endcase
      end
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Flags are computed from the next acc so both land on the same edge.
  ula_flags #(.W(W)) u_flags (
    .value (acc_d),
    .n     (n_d),
    .z     (z_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opreg_q  <= OP_NOP;
      breg_q   <= '0;
      acc_q    <= '0;
      sel_q    <= SEL_SUM;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      flag_n_q <= n_d;
      flag_z_q <= z_d;
      if (accept) begin
        opreg_q <= ins.in_op;
        breg_q  <= ins.in_data;
      end
    end
  end

  assign ins.in_ready = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_RETIRE);
  assign err          = done && is_illegal(opreg_q);
  assign alu_sel      = sel_q;
  assign alu_a        = acc_q;
  assign alu_b        = breg_q;
  assign acc          = acc_q;
  assign flag_n       = flag_n_q;
  assign flag_z       = flag_z_q;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl: directed vector table, hand-written corner sequences
// and random instructions checked against an instruction-level model.
module tb_ula_seq_ctrl;
  import ula_pkg::*;

  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_seq_ctrl_if #(.W(W)) ins ();

  logic [1:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_s, acc;
  logic         flag_n, flag_z, done, err, busy;

  ula_seq_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ins     (ins),
    .alu_sel (alu_sel),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_s   (alu_s),
    .acc     (acc),
    .flag_n  (flag_n),
    .flag_z  (flag_z),
    .done    (done),
    .err     (err),
    .busy    (busy)
  );

  // External Neander ULA: adder plus 4:1 operation mux.
  function automatic logic [W-1:0] ula_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] sel);
    case (sel)
      2'b00:   ula_fn = a + b;
      2'b01:   ula_fn = a | b;
      2'b10:   ula_fn = a & b;
      default: ula_fn = ~a;
    endcase
  endfunction
  assign alu_s = ula_fn(alu_a, alu_b, alu_sel);

  int vectors     = 0;
  int miscompares = 0;
  int acc_m       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level reference: the new accumulator value for one instruction.
  function automatic int ref_exec(input int op, input int d, input int a);
    case (op)
      0:       ref_exec = (a + d) % (MASK + 1);
      1:       ref_exec = a | d;
      2:       ref_exec = a & d;
      3:       ref_exec = (~a) & MASK;
      4:       ref_exec = d & MASK;
      default: ref_exec = a;
    endcase
  endfunction

  function automatic int exp_sel(input int op);
    case (op)
      1:       exp_sel = 1;
      2:       exp_sel = 2;
      3:       exp_sel = 3;
      default: exp_sel = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and check EXEC, RETIRE and the return to IDLE.
  task automatic do_instr(input logic [2:0] op, input logic [W-1:0] d, input int e_acc,
                          input bit e_err, input string tag);
    int guard = 0;
    while (!ins.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_ready"}, ins.in_ready, 1);
    ins.in_valid = 1'b1;
    ins.in_op    = op;
    ins.in_data  = d;
    tick();
    ins.in_valid = 1'b0;
    chk({tag, "_exec_sel"}, alu_sel, exp_sel(op));
    chk({tag, "_exec_ready"}, ins.in_ready, 0);
    chk({tag, "_exec_done"}, done, 0);
    tick();
    chk({tag, "_ret_done"}, done, 1);
    chk({tag, "_ret_err"}, err, e_err);
    chk({tag, "_ret_acc"}, acc, e_acc);
    chk({tag, "_ret_n"}, flag_n, (e_acc >> (W - 1)) & 1);
    chk({tag, "_ret_z"}, flag_z, e_acc == 0);
    chk({tag, "_ret_sel"}, alu_sel, 0);
    chk({tag, "_ret_ready"}, ins.in_ready, 0);
    tick();
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_acc"}, acc, e_acc);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] d;
    int           e_acc;
    bit           e_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int op_r, d_r, e_r;

    tbl[0]  = '{OP_LDA, 3'd5, 5, 1'b0};
    tbl[1]  = '{OP_ADD, 3'd3, 0, 1'b0};
    tbl[2]  = '{OP_LDA, 3'd6, 6, 1'b0};
    tbl[3]  = '{OP_OR,  3'd1, 7, 1'b0};
    tbl[4]  = '{OP_AND, 3'd2, 2, 1'b0};
    tbl[5]  = '{OP_NOT, 3'd0, 5, 1'b0};
    tbl[6]  = '{OP_LDA, 3'd4, 4, 1'b0};
    tbl[7]  = '{3'd7,   3'd3, 4, 1'b1};
    tbl[8]  = '{3'd6,   3'd1, 4, 1'b1};
    tbl[9]  = '{OP_NOP, 3'd7, 4, 1'b0};
    tbl[10] = '{OP_ADD, 3'd7, 3, 1'b0};

    // Reset with a pending instruction that must be ignored.
    ins.in_valid = 1'b1;
    ins.in_op    = OP_LDA;
    ins.in_data  = 3'd7;
    rst          = 1'b1;
    tick();
    tick();
    ins.in_valid = 1'b0;
    rst          = 1'b0;
    chk("rst_acc", acc, 0);
    chk("rst_z", flag_z, 1);
    chk("rst_n", flag_n, 0);
    chk("rst_ready", ins.in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", alu_sel, 0);
    tick();
    chk("rst_idle_acc", acc, 0);

    for (int i = 0; i < 11; i++) begin
      do_instr(tbl[i].op, tbl[i].d, tbl[i].e_acc, tbl[i].e_err, $sformatf("tbl%0d", i));
    end
    acc_m = 3;

    // Continuous in_valid: accepted every third edge.
    do_instr(OP_LDA, 3'd0, 0, 1'b0, "stream_pre");
    ins.in_valid = 1'b1;
    ins.in_op    = OP_ADD;
    ins.in_data  = 3'd1;
    accepts      = 0;
    for (int e = 0; e < 9; e++) begin
      chk($sformatf("stream_ready_e%0d", e), ins.in_ready, (e % 3) == 0);
      if (ins.in_ready) accepts++;
      tick();
    end
    ins.in_valid = 1'b0;
    chk("stream_accepts", accepts, 3);
    chk("stream_acc", acc, 3);
    chk("stream_ready_end", ins.in_ready, 1);

    // Reset in EXEC discards the instruction.
    do_instr(OP_LDA, 3'd1, 1, 1'b0, "midrst_pre");
    ins.in_valid = 1'b1;
    ins.in_op    = OP_ADD;
    ins.in_data  = 3'd2;
    tick();
    ins.in_valid = 1'b0;
    chk("midrst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_acc", acc, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_ready", ins.in_ready, 1);
    chk("midrst_z", flag_z, 1);
    chk("midrst_sel", alu_sel, 0);
    tick();
    chk("midrst_done2", done, 0);
    chk("midrst_acc2", acc, 0);
    acc_m = 0;

    // Random instructions against the reference model.
    for (int k = 0; k < 150; k++) begin
      op_r = int'($urandom_range(0, 7));
      d_r  = int'($urandom_range(0, MASK));
      e_r  = ref_exec(op_r, d_r, acc_m);
      repeat ($urandom_range(0, 2)) tick();
      do_instr(op_r[2:0], d_r[W-1:0], e_r, (op_r >= 6), $sformatf("rnd%0d", k));
      acc_m = e_r;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
